// File: rtl/pc_seq_pkg.sv
// Shared state/select types and program label addresses for the PC sequencer.
// The optional taken-jump counter is enabled with BRANCH_COUNT_EN.
package pc_seq_pkg;

   localparam int unsigned LABEL_W    = 8;
   localparam int unsigned BR_COUNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } seq_state_e;

   typedef enum logic [1:0] {
      SEL_HOLD   = 2'd0,
      SEL_INC    = 2'd1,
      SEL_TARGET = 2'd2,
      SEL_RESET  = 2'd3
   } pc_sel_e;

   // Program labels of the fetched code image
   localparam logic [LABEL_W-1:0] LBL_MAIN    = 8'h04;
   localparam logic [LABEL_W-1:0] LBL_LOOP    = 8'h10;
   localparam logic [LABEL_W-1:0] LBL_SUMA    = 8'h38;
   localparam logic [LABEL_W-1:0] LBL_SUMAAUX = 8'h50;
   localparam logic [LABEL_W-1:0] LBL_DONE    = 8'h70;
   localparam logic [LABEL_W-1:0] LBL_EXIT    = 8'h80;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bus between the PC sequencer and its neighbours.
// br_count is present only when BRANCH_COUNT_EN is defined.
interface pc_sequencer_if
   import pc_seq_pkg::*;
#(
   parameter int unsigned PC_W = 8
);

   logic            start;
   logic            stall;
   logic            br_taken;
   logic [PC_W-1:0] br_target;
   logic            imem_ready;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            flush;
   logic            halted;

`ifdef BRANCH_COUNT_EN
   logic [BR_COUNT_W-1:0] br_count;

   modport master (
      output start, stall, br_taken, br_target, imem_ready,
      input  imem_req, imem_addr, flush, halted, br_count
   );

   modport slave (
      input  start, stall, br_taken, br_target, imem_ready,
      output imem_req, imem_addr, flush, halted, br_count
   );
`else
   modport master (
      output start, stall, br_taken, br_target, imem_ready,
      input  imem_req, imem_addr, flush, halted
   );

   modport slave (
      input  start, stall, br_taken, br_target, imem_ready,
      output imem_req, imem_addr, flush, halted
   );
`endif

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC mux: hold, sequential increment (wrapping), word-aligned jump target, or restart address.
module pc_next_sel
   import pc_seq_pkg::*;
#(
   parameter int unsigned     PC_W     = 8,
   parameter int unsigned     STEP     = 4,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(LBL_MAIN)
) (
   input  pc_sel_e         sel,
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] br_target,
   output logic [PC_W-1:0] pc_next_c
);

   localparam logic [PC_W-1:0] STEP_INC   = PC_W'(STEP);
   localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

   // Increment wraps naturally at PC_W bits; jump targets drop the byte offset
   always_comb begin
      pc_next_c = pc;
      case (sel)
         SEL_HOLD:   pc_next_c = pc;
         SEL_INC:    pc_next_c = pc + STEP_INC;
         SEL_TARGET: pc_next_c = br_target & ALIGN_MASK;
         SEL_RESET:  pc_next_c = RESET_PC;
         default:    pc_next_c = pc;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/FLUSH/HALT control with jump flush and halt on the exit label.
// Define BRANCH_COUNT_EN to add the saturating taken-jump counter br_count.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned     PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(LBL_MAIN),
   parameter logic [PC_W-1:0] EXIT_PC  = PC_W'(LBL_EXIT),
   parameter int unsigned     STEP     = 4
) (
   input logic           clk,
   input logic           rst_n,
   pc_sequencer_if.slave bus
);

   seq_state_e      state;
   seq_state_e      state_next;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_next_c;
   pc_sel_e         pc_sel;
   logic            imem_req_c;
   logic            flush_c;
   logic            halted_c;

   pc_next_sel #(
      .PC_W     (PC_W),
      .STEP     (STEP),
      .RESET_PC (RESET_PC)
   ) u_pc_next_sel (
      .sel       (pc_sel),
      .pc        (pc),
      .br_target (bus.br_target),
      .pc_next_c (pc_next_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next_c;
      end
   end

   // Jumps win over stall and ready; the exit label halts instead of advancing
   always_comb begin
      state_next = state;
      pc_sel     = SEL_HOLD;
      imem_req_c = 1'b0;
      flush_c    = 1'b0;
      halted_c   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               pc_sel     = SEL_RESET;
               state_next = FETCH;
            end
         end
         FETCH: begin
            imem_req_c = !bus.stall;
            if (bus.br_taken) begin
               flush_c    = 1'b1;
               pc_sel     = SEL_TARGET;
               state_next = FLUSH;
            end else if (!bus.stall && bus.imem_ready) begin
               if (pc == EXIT_PC) begin
                  state_next = HALT;
               end else begin
                  pc_sel = SEL_INC;
               end
            end
         end
         FLUSH: begin
            state_next = FETCH;
         end
         HALT: begin
            halted_c = 1'b1;
            if (bus.start) begin
               pc_sel     = SEL_RESET;
               state_next = FETCH;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs decode directly from the state register so reset clears them at once
   assign bus.imem_req  = imem_req_c;
   assign bus.imem_addr = pc;
   assign bus.flush     = flush_c;
   assign bus.halted    = halted_c;

`ifdef BRANCH_COUNT_EN
   logic                  restart_c;
   logic                  br_accept_c;
   logic [BR_COUNT_W-1:0] br_count;

   assign restart_c   = bus.start && ((state == IDLE) || (state == HALT));
   assign br_accept_c = bus.br_taken && (state == FETCH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count <= '0;
      end else if (restart_c) begin
         br_count <= '0;
      end else if (br_accept_c && (br_count != '1)) begin
         br_count <= br_count + BR_COUNT_W'(1);
      end
   end

   assign bus.br_count = br_count;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, reset/wrap sequences, random run against a model.
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   localparam int unsigned PC_W = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   pc_sequencer_if #(.PC_W(PC_W)) bus ();

   pc_sequencer #(
      .PC_W     (PC_W),
      .RESET_PC (8'h04),
      .EXIT_PC  (8'h80),
      .STEP     (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0] ctl;   // {start, stall, br_taken, imem_ready}
      logic [7:0] tgt;
      logic [2:0] ex;    // {imem_req, flush, halted}
      logic [7:0] addr;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: running/bubble/done flags, pc and jump count as plain integers
   bit m_running;
   bit m_bubble;
   bit m_done;
   int m_pc;
   int m_cnt;

   function automatic vec_t v(input logic [3:0] ctl, input logic [7:0] tgt,
                              input logic [2:0] ex, input logic [7:0] addr);
      vec_t r;
      r.ctl  = ctl;
      r.tgt  = tgt;
      r.ex   = ex;
      r.addr = addr;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic sl, input logic br,
                        input logic [7:0] tg, input logic rd);
      bus.start      = st;
      bus.stall      = sl;
      bus.br_taken   = br;
      bus.br_target  = tg;
      bus.imem_ready = rd;
   endtask

   function automatic void model_reset();
      m_running = 1'b0;
      m_bubble  = 1'b0;
      m_done    = 1'b0;
      m_pc      = 4;
      m_cnt     = 0;
   endfunction

   function automatic void model_step();
      if (!m_running) begin
         if (bus.start) begin
            m_running = 1'b1;
            m_bubble  = 1'b0;
            m_done    = 1'b0;
            m_pc      = 4;
            m_cnt     = 0;
         end
      end else if (m_bubble) begin
         m_bubble = 1'b0;
      end else if (bus.br_taken) begin
         m_pc     = (int'(bus.br_target) / 4) * 4;
         m_bubble = 1'b1;
         if (m_cnt < 65535) m_cnt++;
      end else if (!bus.stall && bus.imem_ready) begin
         if (m_pc == 'h80) begin
            m_running = 1'b0;
            m_done    = 1'b1;
         end else begin
            m_pc = (m_pc + 4) % 256;
         end
      end
   endfunction

   task automatic check_model();
      bit live;
      live = m_running && !m_bubble;
      check("imem_req",  32'(bus.imem_req),  32'(live && !bus.stall));
      check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      check("flush",     32'(bus.flush),     32'(live && bus.br_taken));
      check("halted",    32'(bus.halted),    32'(m_done));
`ifdef BRANCH_COUNT_EN
      check("br_count",  32'(bus.br_count),  32'(m_cnt));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic step(input logic st, input logic sl, input logic br,
                       input logic [7:0] tg, input logic rd);
      drive(st, sl, br, tg, rd);
      #1;
      check_model();
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_imem_req"},  32'(bus.imem_req),  32'(0));
      check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'(8'h04));
      check({tag, "_flush"},     32'(bus.flush),     32'(0));
      check({tag, "_halted"},    32'(bus.halted),    32'(0));
`ifdef BRANCH_COUNT_EN
      check({tag, "_br_count"},  32'(bus.br_count),  32'(0));
`endif
   endtask

   initial begin
      vec_t tbl [0:27];
      logic st, sl, br, rd;
      logic [7:0] tg;

      tbl = '{
         v(4'b0001, 8'h00, 3'b000, 8'h04),  // idle, no start
         v(4'b1001, 8'h00, 3'b000, 8'h04),  // start sampled
         v(4'b0001, 8'h00, 3'b100, 8'h04),
         v(4'b0001, 8'h00, 3'b100, 8'h08),
         v(4'b0001, 8'h00, 3'b100, 8'h0C),
         v(4'b0011, 8'h38, 3'b110, 8'h10),  // jump loop -> suma
         v(4'b0011, 8'h70, 3'b000, 8'h38),  // flush bubble, jump ignored
         v(4'b0101, 8'h00, 3'b000, 8'h38),  // stalled
         v(4'b0001, 8'h00, 3'b100, 8'h38),
         v(4'b0111, 8'h3B, 3'b010, 8'h3C),  // jump overrides stall, target aligned
         v(4'b1001, 8'h00, 3'b000, 8'h38),  // start ignored in flush
         v(4'b1001, 8'h00, 3'b100, 8'h38),  // start ignored in fetch
         v(4'b0011, 8'h50, 3'b110, 8'h3C),
         v(4'b0001, 8'h00, 3'b000, 8'h50),
         v(4'b0101, 8'h00, 3'b000, 8'h50),  // 3-cycle stall at sumaaux
         v(4'b0101, 8'h00, 3'b000, 8'h50),
         v(4'b0101, 8'h00, 3'b000, 8'h50),
         v(4'b0001, 8'h00, 3'b100, 8'h50),
         v(4'b0011, 8'h7F, 3'b110, 8'h54),
         v(4'b0001, 8'h00, 3'b000, 8'h7C),
         v(4'b0001, 8'h00, 3'b100, 8'h7C),
         v(4'b0001, 8'h00, 3'b100, 8'h80),  // exit accepted
         v(4'b0011, 8'h10, 3'b001, 8'h80),  // jump ignored in halt
         v(4'b0000, 8'h00, 3'b001, 8'h80),
         v(4'b1000, 8'h00, 3'b001, 8'h80),  // restart
         v(4'b0000, 8'h00, 3'b100, 8'h04),  // not ready: hold
         v(4'b0001, 8'h00, 3'b100, 8'h04),
         v(4'b0001, 8'h00, 3'b100, 8'h08)
      };

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 28; i++) begin
         drive(tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].tgt, tbl[i].ctl[0]);
         #1;
         check($sformatf("tbl%0d_imem_req", i),  32'(bus.imem_req),  32'(tbl[i].ex[2]));
         check($sformatf("tbl%0d_flush", i),     32'(bus.flush),     32'(tbl[i].ex[1]));
         check($sformatf("tbl%0d_halted", i),    32'(bus.halted),    32'(tbl[i].ex[0]));
         check($sformatf("tbl%0d_imem_addr", i), 32'(bus.imem_addr), 32'(tbl[i].addr));
`ifdef BRANCH_COUNT_EN
         if (i == 24) check("br_count_before_start", 32'(bus.br_count), 32'(4));
         if (i == 25) check("br_count_after_start",  32'(bus.br_count), 32'(0));
`endif
         tick();
      end

      // Reset asserted while in FLUSH
      step(1'b0, 1'b0, 1'b1, 8'h38, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      #1;
      check_model();
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_in_flush");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Reset asserted mid-fetch while a jump is flushing
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 8'h20, 1'b1);
      #1;
      check_model();
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_in_fetch");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Without start the block stays idle after reset release
      repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Wrap from FC to 00
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 1'b1, 8'hFE, 1'b1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check("wrap_pre_addr", 32'(bus.imem_addr), 32'(8'hFC));
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      #1;
      check("wrap_addr", 32'(bus.imem_addr), 32'(8'h00));
      check_model();
      tick();

      // Random run against the model
      for (int c = 0; c < 3000; c++) begin
         st = m_running ? ($urandom_range(0, 30) == 0) : ($urandom_range(0, 2) == 0);
         sl = ($urandom_range(0, 3) == 0);
         br = ($urandom_range(0, 7) == 0);
         rd = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) tg = 8'h70 + 8'($urandom_range(0, 16));
         else tg = 8'($urandom);
         step(st, sl, br, tg, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
